tmp_readout: RTL and testbench

Digital readout for the temperature sensor front-end: consumes the comparator decision stream that the sensor sequencer produces, one decision per `sample` strobe. Discards a settling prefix, counts comparator-high decisions over a fixed frame and delivers the count as a temperature code on a valid/ready interface. Sits between the sensor sequencer and the register/SPI layer, in the same `clk` domain as the sequencer.

---
 rtl/tmp_readout_pkg.sv | 16 +
 rtl/tmp_frame_acc.sv | 36 +++
 rtl/tmp_readout.sv | 112 +++++++++++
 tb/tb_tmp_readout.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/tmp_readout_pkg.sv
// rtl/tmp_readout_pkg.sv - shared types and helpers for the temperature sensor readout
package tmp_readout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCUM  = 2'd2,
        ST_HOLD   = 2'd3
    } tmp_state_t;

    // Code width able to hold every count 0..frame_len inclusive.
    function automatic int tmp_code_w(input int frame_len);
        return $clog2(frame_len) + 1;
    endfunction

endpackage

// File: rtl/tmp_frame_acc.sv
// rtl/tmp_frame_acc.sv - frame sample counter and comparator-ones accumulator
module tmp_frame_acc #(
    parameter int FRAME_LEN = 256,
    parameter int CODE_W    = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic              bit_in,
    output logic              done,
    output logic [CODE_W-1:0] sum
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]  frame_cnt;
    logic [CODE_W-1:0] ones_cnt;

    // sum already includes the current decision so the completing sample is counted
    assign done = en && (frame_cnt == CNT_LAST);
    assign sum  = ones_cnt + CODE_W'(bit_in);

    // Counters zero on clear or at frame end so a following sample opens a new frame
    always_ff @(posedge clk) begin
        if (reset || clr || done) begin
            frame_cnt <= '0;
            ones_cnt  <= '0;
        end else if (en) begin
            frame_cnt <= frame_cnt + 1'b1;
            ones_cnt  <= sum;
        end
    end

endmodule

// File: rtl/tmp_readout.sv
// rtl/tmp_readout.sv - settle/accumulate readout FSM with valid/ready code output
module tmp_readout
    import tmp_readout_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int SETTLE    = 4,
    localparam int CODE_W   = tmp_code_w(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmp,
    input  logic              sample,
    input  logic              start,
    input  logic              cont,
    output logic              busy,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              overrun
);

    // Extra headroom keeps the counter non-degenerate when SETTLE is 0
    localparam int SET_W = $clog2(SETTLE + 2);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    tmp_state_t        state, state_next;
    logic [SET_W-1:0]  settle_cnt;
    logic              settle_inc;
    logic              acc_clr, acc_en, acc_done;
    logic              start_ok;
    logic              handshake;
    logic [CODE_W-1:0] acc_sum;

    assign handshake = code_valid && code_ready;
    assign busy      = (state == ST_SETTLE) || (state == ST_ACCUM);

    tmp_frame_acc #(
        .FRAME_LEN (FRAME_LEN),
        .CODE_W    (CODE_W)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (cmp),
        .done   (acc_done),
        .sum    (acc_sum)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state and counter control; a sample coinciding with start is dropped
    always_comb begin
        state_next = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        settle_inc = 1'b0;
        start_ok   = 1'b0;
        case (state)
            ST_IDLE: begin
                acc_clr = 1'b1;
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (sample) begin
                    if (settle_cnt == SET_LAST) state_next = ST_ACCUM;
                    else                        settle_inc = 1'b1;
                end
            end
            ST_ACCUM: begin
                acc_en = sample;
                if (acc_done && !cont) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (handshake) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Discard counter, held at zero outside SETTLE
    always_ff @(posedge clk) begin
        if (reset || state != ST_SETTLE) settle_cnt <= '0;
        else if (settle_inc)             settle_cnt <= settle_cnt + 1'b1;
    end

    // Output register: frame completion wins over a same-cycle handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            code       <= '0;
            code_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (start_ok) overrun <= 1'b0;
            if (acc_done) begin
                code       <= acc_sum;
                code_valid <= 1'b1;
                if (code_valid && !code_ready) overrun <= 1'b1;
            end else if (handshake) begin
                code_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tmp_readout.sv
// tb/tb_tmp_readout.sv - directed table-driven bench for tmp_readout
module tb_tmp_readout;

    localparam int FRAME_LEN = 16;
    localparam int SETTLE    = 2;
    localparam int CODE_W    = 5;

    logic              clk = 1'b0;
    logic              reset, cmp, sample, start, cont, code_ready;
    logic              busy, code_valid, overrun;
    logic [CODE_W-1:0] code;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [15:0] pattern;
        int          exp_code;
    } vec_t;

    vec_t vecs[7];

    tmp_readout #(.FRAME_LEN(FRAME_LEN), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmp        (cmp),
        .sample     (sample),
        .start      (start),
        .cont       (cont),
        .busy       (busy),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_sample(input logic b);
        sample = 1'b1;
        cmp    = b;
        tick();
        sample = 1'b0;
        cmp    = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One frame of samples; optional start pulse or ready pulse on a given sample index
    task automatic run_frame(input logic [15:0] pat, input int start_at, input int ready_at);
        for (int i = 0; i < FRAME_LEN; i++) begin
            start      = (i == start_at);
            code_ready = (i == ready_at);
            do_sample(pat[i]);
            start      = 1'b0;
            code_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic accept();
        code_ready = 1'b1;
        tick();
        code_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h001F, 5};
        vecs[1] = '{16'h0000, 0};
        vecs[2] = '{16'hFFFF, 16};
        vecs[3] = '{16'hA5A5, 8};
        vecs[4] = '{16'h0007, 3};
        vecs[5] = '{16'h07FF, 11};
        vecs[6] = '{16'h8001, 2};

        reset = 1'b0; cmp = 1'b0; sample = 1'b0; start = 1'b0;
        cont = 1'b0; code_ready = 1'b0;
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_code", code, 0);
        chk("reset_valid", code_valid, 0);
        chk("reset_overrun", overrun, 0);

        // Single-shot conversions; settle samples are 1 and must be discarded
        for (int v = 0; v < 7; v++) begin
            do_start();
            chk($sformatf("v%0d_busy_after_start", v), busy, 1);
            do_sample(1'b1);
            do_sample(1'b1);
            chk($sformatf("v%0d_valid_before", v), code_valid, 0);
            run_frame(vecs[v].pattern, (v == 3) ? 5 : -1, -1);
            chk($sformatf("v%0d_code", v), code, vecs[v].exp_code);
            chk($sformatf("v%0d_valid", v), code_valid, 1);
            chk($sformatf("v%0d_busy_done", v), busy, 0);
            if (v == 0) begin
                for (int c = 0; c < 10; c++) tick();
                chk("hold_code_stable", code, 5);
                chk("hold_valid_stable", code_valid, 1);
                start = 1'b1;
                do_sample(1'b1);
                start = 1'b0;
                chk("hold_sample_ignored", code, 5);
                chk("hold_start_ignored", busy, 0);
            end
            accept();
            chk($sformatf("v%0d_valid_cleared", v), code_valid, 0);
            chk($sformatf("v%0d_idle", v), busy, 0);
            chk($sformatf("v%0d_overrun", v), overrun, 0);
        end

        // Continuous: 3 ones, accept, 11 ones, then 2 ones with same-cycle handshake
        cont = 1'b1;
        do_start();
        do_sample(1'b0);
        do_sample(1'b0);
        run_frame(16'h0007, -1, -1);
        chk("cont_code_a", code, 3);
        chk("cont_busy_a", busy, 1);
        accept();
        chk("cont_accept_a", code_valid, 0);
        run_frame(16'h07FF, -1, -1);
        chk("cont_code_b", code, 11);
        chk("cont_overrun_b", overrun, 0);
        run_frame(16'h8001, -1, FRAME_LEN - 1);
        chk("same_cycle_code", code, 2);
        chk("same_cycle_valid", code_valid, 1);
        chk("same_cycle_overrun", overrun, 0);

        // Continuous with ready withheld: second frame overwrites and flags overrun
        do_reset();
        do_start();
        do_sample(1'b0);
        do_sample(1'b0);
        run_frame(16'h0007, -1, -1);
        chk("ovr_code_a", code, 3);
        run_frame(16'h07FF, -1, -1);
        chk("ovr_code_b", code, 11);
        chk("ovr_valid", code_valid, 1);
        chk("ovr_flag", overrun, 1);
        cont = 1'b0;

        // Start with a sample in the same cycle: that sample is not counted
        do_reset();
        start = 1'b1;
        do_sample(1'b1);
        start = 1'b0;
        do_sample(1'b0);
        do_sample(1'b0);
        run_frame(16'h8000, -1, -1);
        chk("start_sample_code", code, 1);
        chk("start_sample_valid", code_valid, 1);
        accept();

        // Reset mid-ACCUM then a fresh full frame
        do_start();
        do_sample(1'b0);
        do_sample(1'b0);
        for (int i = 0; i < 9; i++) do_sample(1'b1);
        chk("mid_busy", busy, 1);
        do_reset();
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_code", code, 0);
        chk("mid_reset_valid", code_valid, 0);
        chk("mid_reset_overrun", overrun, 0);
        do_start();
        do_sample(1'b0);
        do_sample(1'b0);
        run_frame(16'h00FF, -1, -1);
        chk("fresh_code", code, 8);
        chk("fresh_valid", code_valid, 1);
        accept();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
